operand_stack: RTL and testbench
================================

// Module: operand_stack
// PURPOSE
//  Hardware operand stack serving the multicycle stack-CPU control FSM: executes the push/pop/tos
//  commands the controller issues and returns the top-of-stack word to the A/B operand registers.
//  Single clock, registered read data (1-cycle latency), occupancy tracking, overflow/underflow detection.
// PARAMETERS
//  DATA_W  8  width of one stack word (matches datapath / memory word)
//  DEPTH   8  number of entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH)+1  occupancy counter width (derived, not overridden)
// PORTS
//  clk      in   1       clock, all state updates on rising edge
//  rst      in   1       synchronous reset, active-high
//  push     in   1       write din onto the stack this cycle
//  pop      in   1       remove top; its value appears on dout next cycle
//  tos      in   1       read top without removing; value appears on dout next cycle
//  din      in   DATA_W  push data (ALU result or memory data, muxed outside)
//  dout     out  DATA_W  registered read data
//  empty    out  1       count == 0 (combinational from count)
//  full     out  1       count == DEPTH (combinational from count)
//  count    out  CNT_W   current occupancy
//  err_ovf  out  1       sticky: push attempted while full
//  err_unf  out  1       sticky: pop/tos attempted while empty
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): count=0, dout=0, err_ovf=0, err_unf=0; storage contents not cleared.
//  rst dominates all commands in the same cycle; a command in flight is discarded, dout cleared.
//  Top entry index = count-1; next free index = count (low $clog2(DEPTH) bits).
//  Commands sampled each edge; combinations resolved as:
//   push only        : mem[count] <= din; count <= count+1; dout holds.
//   pop only         : dout <= mem[count-1]; count <= count-1.
//   tos only         : dout <= mem[count-1]; count unchanged.
//   push & pop       : replace top: dout <= old mem[count-1]; mem[count-1] <= din; count unchanged.
//   tos & pop        : treated as pop.
//   tos & push       : dout <= old top (pre-write value); push proceeds.
//   none             : all state holds; dout holds last value.
//  Read-before-write: any read in the same cycle as a write to the same entry returns the OLD data.
//  Boundaries (guard logic, see CONFIGURATION):
//   push when full (no simultaneous pop) -> err_ovf<=1.
//   pop/tos when empty                   -> err_unf<=1; dout <= 0.
//   push & pop when empty                -> err_unf<=1; executes as push only.
//   push & pop when full                 -> legal replace-top, no error.
//  err_ovf/err_unf cleared only by rst.
//  count never exceeds DEPTH or goes below 0 when guarded.
// CONFIGURATION
//  Macro OPERAND_STACK_GUARD_EN:
//   defined     : illegal push (full) leaves count and storage unchanged; illegal pop leaves count at 0;
//                 err_ovf/err_unf set as above.
//   not defined : no guarding; pointer arithmetic wraps modulo DEPTH (push on full overwrites
//                 entry 0 and count wraps to 1-bit-extended value mod 2*DEPTH masked to DEPTH range,
//                 i.e. count <= (count+1) mod (DEPTH+1) not used -- count simply wraps in CNT_W);
//                 err_ovf and err_unf tied to 0; full/empty still reported from count.
// STRUCTURE
//  stack_pkg: STACK_DATA_W, STACK_DEPTH defaults; typedef enum {CMD_NONE, CMD_PUSH, CMD_POP,
//   CMD_TOS, CMD_REPL} stack_cmd_t used by the command decode and by the bench scoreboard.
//  Sub-module stack_ram: DEPTH x DATA_W array, one sync write port, one async read port
//   (registering into dout happens in operand_stack). Pointer/count/error logic stays in top.
// TESTING
//  1 rst; push 0x11,0x22,0x33; tos -> dout=0x33 next cycle, count=3, empty=0.
//  2 from (1): pop,pop,pop -> dout=0x33,0x22,0x11 on successive cycles; count=0, empty=1.
//  3 push DEPTH words 0x01..0x08 -> full=1; push 0xFF -> guarded: count=8, err_ovf=1, top still 0x08.
//  4 empty stack: pop -> err_unf=1, dout=0, count=0; unguarded build: err_unf stays 0.
//  5 stack {0x05,0x07}: push 0x0C & pop same cycle -> dout=0x07, count=2; tos -> dout=0x0C.
//  6 push 0xAA with rst=1 same cycle -> count=0, dout=0, errors 0; following tos -> err_unf=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared defaults and command encoding for the operand stack and its bench.
package stack_pkg;

  localparam int STACK_DATA_W = 8;
  localparam int STACK_DEPTH  = 8;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PUSH,
    CMD_POP,
    CMD_TOS,
    CMD_REPL
  } stack_cmd_t;

  // push+pop means replace-top; pop wins over tos; push+tos stays a push (the tos read is handled separately).
  function automatic stack_cmd_t decode_cmd(input logic push, input logic pop, input logic tos);
    stack_cmd_t c;
    c = CMD_NONE;
    if (push && pop)  c = CMD_REPL;
    else if (push)    c = CMD_PUSH;
    else if (pop)     c = CMD_POP;
    else if (tos)     c = CMD_TOS;
    return c;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Zero-latency read, write lands on the clock edge, no backpressure.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/operand_stack.sv
// Operand stack for the stack-CPU controller; dout is registered (1-cycle latency), no backpressure.
// Define OPERAND_STACK_GUARD_EN to block illegal push/pop and enable the sticky err_ovf/err_unf flags.
module operand_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   tos,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_ovf,
  output logic                   err_unf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;

  stack_cmd_t        w_cmd;
  logic              w_empty, w_full;
  logic [AW-1:0]     w_top_idx, w_free_idx, w_waddr;
  logic [DATA_W-1:0] w_top_dat;
  logic              w_rd, w_repl, w_push_req, w_do_push, w_do_pop, w_we;

  assign w_cmd      = decode_cmd(push, pop, tos);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_free_idx = r_count[AW-1:0];
  assign w_top_idx  = r_count[AW-1:0] - AW'(1);

  // Replace-top on an empty stack has no top to read or overwrite, so it degrades to a plain push.
  assign w_repl     = (w_cmd == CMD_REPL) && !w_empty;
  assign w_push_req = (w_cmd == CMD_PUSH) || ((w_cmd == CMD_REPL) && w_empty);
  assign w_rd       = (pop || tos) && !((w_cmd == CMD_REPL) && w_empty);

`ifdef OPERAND_STACK_GUARD_EN
  assign w_do_push = w_push_req && !w_full;
  assign w_do_pop  = (w_cmd == CMD_POP) && !w_empty;
`else
  assign w_do_push = w_push_req;
  assign w_do_pop  = (w_cmd == CMD_POP);
`endif

  assign w_we    = !rst && (w_do_push || w_repl);
  assign w_waddr = w_repl ? w_top_idx : w_free_idx;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_raddr (w_top_idx),
    .o_rdata (w_top_dat)
  );

  // The async read sees pre-edge contents, so a same-cycle write to the top returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_do_push)     r_count <= r_count + CNT_ONE;
      else if (w_do_pop) r_count <= r_count - CNT_ONE;
      if (w_rd)          r_dout  <= w_empty ? '0 : w_top_dat;
    end
  end

`ifdef OPERAND_STACK_GUARD_EN
  logic r_err_ovf, r_err_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_push_req && w_full)  r_err_ovf <= 1'b1;
      if ((pop || tos) && w_empty) r_err_unf <= 1'b1;
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

  assign dout  = r_dout;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: vector table for normal traffic plus hand sequences for boundaries.
module tb_operand_stack;
  import stack_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic             clk = 1'b0;
  logic             rst, push, pop, tos;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic             empty, full, err_ovf, err_unf;
  logic [3:0]       count;

  int errors = 0;
  int checks = 0;

`ifdef OPERAND_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  operand_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .din     (din),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push, pop, tos;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [3:0] exp_count;
    logic       exp_empty, exp_full;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic step(input logic r, input logic p, input logic q, input logic t, input logic [7:0] d);
    rst = r; push = p; pop = q; tos = t; din = d;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    //          push pop tos din    dout   cnt emp full
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 4'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 4'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 4'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 4'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 4'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 4'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 4'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h11, 4'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h07, 8'h11, 4'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h0C, 8'h07, 4'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h0C, 4'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h44, 8'h0C, 4'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h44, 4'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h99, 8'h44, 4'd2, 1'b0, 1'b0};

    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
    @(negedge clk);
    do_reset();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_dout",  32'(dout),  32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full",  32'(full),  32'd0);
    chk("reset_errs",  32'({err_ovf, err_unf}), 32'd0);

    for (int i = 0; i < 14; i++) begin
      step(1'b0, vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].din);
      chk($sformatf("vec%0d_dout", i),  32'(dout),  32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_flags", i), 32'({empty, full}), 32'({vecs[i].exp_empty, vecs[i].exp_full}));
      chk($sformatf("vec%0d_errs", i),  32'({err_ovf, err_unf}), 32'd0);
    end

    // Fill to DEPTH, then push once more.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    chk("ovf_count", 32'(count),   GUARD ? 32'd8 : 32'd9);
    chk("ovf_full",  32'(full),    GUARD ? 32'd1 : 32'd0);
    chk("ovf_err",   32'(err_ovf), GUARD ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_top",   32'(dout),    GUARD ? 32'h08 : 32'hFF);

    // Replace-top while full is legal.
    if (GUARD) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5C);
      chk("repl_full_dout",  32'(dout),  32'h08);
      chk("repl_full_count", 32'(count), 32'd8);
    end

    // Pop from an empty stack.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_err",   32'(err_unf), GUARD ? 32'd1 : 32'd0);
    chk("unf_dout",  32'(dout),    32'd0);
    chk("unf_count", 32'(count),   GUARD ? 32'd0 : 32'hF);

    // Push & pop on empty behaves as a push.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h3E);
    chk("pp_empty_count", 32'(count),   32'd1);
    chk("pp_empty_err",   32'(err_unf), GUARD ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("pp_empty_top",   32'(dout),    32'h3E);

    // Reset dominates a same-cycle push.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("pre_rst_dout", 32'(dout), 32'h5A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    chk("rst_push_count", 32'(count), 32'd0);
    chk("rst_push_dout",  32'(dout),  32'd0);
    chk("rst_push_errs",  32'({err_ovf, err_unf}), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("rst_tos_err",   32'(err_unf), GUARD ? 32'd1 : 32'd0);
    chk("rst_tos_count", 32'(count),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
